// File: rtl/fir_job_sequencer_pkg.sv
// Shared types for the FIR job sequencer: FSM state encoding and the
// request bundle shape used by the streamer channels.
package fir_job_sequencer_pkg;

  localparam int FIR_NB_TAPS    = 50;
  localparam int FIR_LEN_WIDTH  = 16;
  localparam int FIR_ADDR_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LOAD_H  = 3'd2,
    WAIT_H  = 3'd3,
    STREAM  = 3'd4,
    WAIT_XY = 3'd5,
    DONE    = 3'd6
  } fir_seq_state_t;

  // Request as seen by a streamer channel; len is wide enough for the x stream.
  typedef struct packed {
    logic                      req;
    logic [FIR_ADDR_WIDTH-1:0] addr;
    logic [FIR_LEN_WIDTH:0]    len;
  } fir_seq_req_t;

endpackage

// File: rtl/fir_job_sequencer_channel.sv
// One streamer channel handshake: raises req with a stable addr/len on
// launch, holds it until ack, remembers that the request was accepted and
// keeps a sticky flag for the channel-complete pulse.
module fir_seq_channel #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  launch,
  input  logic                  en,
  input  logic                  ack,
  input  logic                  done_pulse,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [LEN_W-1:0]      cfg_len,
  output logic                  req,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [LEN_W-1:0]      len,
  output logic                  accepted,
  output logic                  done_seen
);

  logic                  req_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [LEN_W-1:0]      len_r;
  logic                  acc_r;
  logic                  done_r;

  // Request/flag register: launch beats clear, clear beats handshake and done.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_r  <= 1'b0;
      addr_r <= {ADDR_WIDTH{1'b0}};
      len_r  <= {LEN_W{1'b0}};
      acc_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (launch) begin
      req_r  <= 1'b1;
      addr_r <= cfg_addr;
      len_r  <= cfg_len;
      acc_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (clr) begin
      req_r  <= 1'b0;
      addr_r <= {ADDR_WIDTH{1'b0}};
      len_r  <= {LEN_W{1'b0}};
      acc_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      if (req_r && ack) begin
        req_r <= 1'b0;
        acc_r <= 1'b1;
      end
      if (en && done_pulse) begin
        done_r <= 1'b1;
      end
    end
  end

  assign req       = req_r;
  assign addr      = addr_r;
  assign len       = len_r;
  assign accepted  = acc_r;
  assign done_seen = done_r;

endmodule

// File: rtl/fir_job_sequencer.sv
// FIR job sequencer: clear, coefficient load, tap-buffer fill, then x/y
// streaming, then a one-cycle done pulse. All outputs come from flops.
module fir_job_sequencer
  import fir_job_sequencer_pkg::*;
#(
  parameter int NB_TAPS    = FIR_NB_TAPS,
  parameter int LEN_WIDTH  = FIR_LEN_WIDTH,
  parameter int ADDR_WIDTH = FIR_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  soft_clear_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [ADDR_WIDTH-1:0] x_addr_i,
  input  logic [ADDR_WIDTH-1:0] h_addr_i,
  input  logic [ADDR_WIDTH-1:0] y_addr_i,
  output logic                  h_src_req_o,
  input  logic                  h_src_ack_i,
  output logic [ADDR_WIDTH-1:0] h_src_addr_o,
  output logic [LEN_WIDTH-1:0]  h_src_len_o,
  output logic                  x_src_req_o,
  input  logic                  x_src_ack_i,
  output logic [ADDR_WIDTH-1:0] x_src_addr_o,
  output logic [LEN_WIDTH:0]    x_src_len_o,
  output logic                  y_sink_req_o,
  input  logic                  y_sink_ack_i,
  output logic [ADDR_WIDTH-1:0] y_sink_addr_o,
  output logic [LEN_WIDTH-1:0]  y_sink_len_o,
  input  logic                  h_src_done_i,
  input  logic                  x_src_done_i,
  input  logic                  y_sink_done_i,
  input  logic                  tap_hs_i,
  output logic                  clear_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int                   CNT_W     = $clog2(NB_TAPS + 1);
  localparam logic [CNT_W-1:0]     TAPS_C    = CNT_W'(NB_TAPS);
  localparam logic [LEN_WIDTH-1:0] H_LEN_C   = LEN_WIDTH'(NB_TAPS);
  localparam logic [LEN_WIDTH:0]   X_EXTRA_C = (LEN_WIDTH + 1)'(NB_TAPS - 1);

  fir_seq_state_t        state_r, state_s;
  logic [LEN_WIDTH-1:0]  cfg_len_r;
  logic [ADDR_WIDTH-1:0] cfg_x_addr_r, cfg_h_addr_r, cfg_y_addr_r;
  logic [CNT_W-1:0]      tap_cnt_r;
  logic                  clear_r, busy_r, done_r;
  logic                  clear_s, busy_s, done_s;
  logic                  accept_start_s, seq_clr_s;
  logic                  h_launch_s, xy_launch_s, h_en_s, xy_en_s;
  logic                  h_acc_r, x_acc_r, y_acc_r;
  logic                  h_acc_s, x_acc_s, y_acc_s;
  logic                  h_done_r, x_done_r, y_done_r;
  logic [LEN_WIDTH:0]    x_len_s;

  assign accept_start_s = (state_r == IDLE) && start_i && !soft_clear_i;
  assign seq_clr_s      = soft_clear_i || (state_r == CLEAR);
  assign h_en_s         = (state_r == LOAD_H) || (state_r == WAIT_H);
  assign xy_en_s        = (state_r == STREAM) || (state_r == WAIT_XY);
  assign h_acc_s        = h_acc_r || (h_src_req_o && h_src_ack_i);
  assign x_acc_s        = x_acc_r || (x_src_req_o && x_src_ack_i);
  assign y_acc_s        = y_acc_r || (y_sink_req_o && y_sink_ack_i);
  // One extra bit so len + NB_TAPS - 1 never wraps.
  assign x_len_s        = {1'b0, cfg_len_r} + X_EXTRA_C;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; soft clear overrides any handshake or completion.
  always_comb begin
    state_s = state_r;
    if (soft_clear_i) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_s = (len_i == {LEN_WIDTH{1'b0}}) ? DONE : CLEAR;
          end else begin
            state_s = IDLE;
          end
        end
        CLEAR:   state_s = LOAD_H;
        LOAD_H:  state_s = h_acc_s ? WAIT_H : LOAD_H;
        WAIT_H:  state_s = ((tap_cnt_r == TAPS_C) && h_done_r) ? STREAM : WAIT_H;
        STREAM:  state_s = (x_acc_s && y_acc_s) ? WAIT_XY : STREAM;
        WAIT_XY: state_s = (x_done_r && y_done_r) ? DONE : WAIT_XY;
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    clear_s     = soft_clear_i || (state_s == CLEAR);
    busy_s      = (state_s != IDLE);
    done_s      = (state_s == DONE);
    h_launch_s  = (state_r == CLEAR) && (state_s == LOAD_H);
    xy_launch_s = (state_r == WAIT_H) && (state_s == STREAM);
  end

  // Registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clear_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      clear_r <= clear_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Job configuration, captured only on an accepted start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_len_r    <= {LEN_WIDTH{1'b0}};
      cfg_x_addr_r <= {ADDR_WIDTH{1'b0}};
      cfg_h_addr_r <= {ADDR_WIDTH{1'b0}};
      cfg_y_addr_r <= {ADDR_WIDTH{1'b0}};
    end else if (accept_start_s) begin
      cfg_len_r    <= len_i;
      cfg_x_addr_r <= x_addr_i;
      cfg_h_addr_r <= h_addr_i;
      cfg_y_addr_r <= y_addr_i;
    end
  end

  // Tap counter, saturating at NB_TAPS, live while coefficients stream in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tap_cnt_r <= {CNT_W{1'b0}};
    end else if (seq_clr_s) begin
      tap_cnt_r <= {CNT_W{1'b0}};
    end else if (h_en_s && tap_hs_i && (tap_cnt_r != TAPS_C)) begin
      tap_cnt_r <= tap_cnt_r + CNT_W'(1);
    end
  end

  fir_seq_channel #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_W(LEN_WIDTH)) u_h_chan (
    .clk(clk_i), .rst(rst_i), .clr(seq_clr_s), .launch(h_launch_s), .en(h_en_s),
    .ack(h_src_ack_i), .done_pulse(h_src_done_i),
    .cfg_addr(cfg_h_addr_r), .cfg_len(H_LEN_C),
    .req(h_src_req_o), .addr(h_src_addr_o), .len(h_src_len_o),
    .accepted(h_acc_r), .done_seen(h_done_r)
  );

  fir_seq_channel #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_W(LEN_WIDTH + 1)) u_x_chan (
    .clk(clk_i), .rst(rst_i), .clr(seq_clr_s), .launch(xy_launch_s), .en(xy_en_s),
    .ack(x_src_ack_i), .done_pulse(x_src_done_i),
    .cfg_addr(cfg_x_addr_r), .cfg_len(x_len_s),
    .req(x_src_req_o), .addr(x_src_addr_o), .len(x_src_len_o),
    .accepted(x_acc_r), .done_seen(x_done_r)
  );

  fir_seq_channel #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_W(LEN_WIDTH)) u_y_chan (
    .clk(clk_i), .rst(rst_i), .clr(seq_clr_s), .launch(xy_launch_s), .en(xy_en_s),
    .ack(y_sink_ack_i), .done_pulse(y_sink_done_i),
    .cfg_addr(cfg_y_addr_r), .cfg_len(cfg_len_r),
    .req(y_sink_req_o), .addr(y_sink_addr_o), .len(y_sink_len_o),
    .accepted(y_acc_r), .done_seen(y_done_r)
  );

  assign clear_o = clear_r;
  assign busy_o  = busy_r;
  assign done_o  = done_r;

endmodule

// File: tb/tb_fir_job_sequencer.sv
// Directed bench for fir_job_sequencer with a phase-level reference model
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_fir_job_sequencer;
  import fir_job_sequencer_pkg::*;

  localparam int NB = 4;
  localparam int LW = 16;
  localparam int AW = 32;

  localparam int PH_IDLE = 0, PH_CLEAR = 1, PH_HLOAD = 2, PH_HFILL = 3,
                 PH_XY = 4, PH_XYWAIT = 5, PH_FIN = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i = 1'b1, start_i = 1'b0, soft_clear_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic [AW-1:0] x_addr_i = '0, h_addr_i = '0, y_addr_i = '0;
  logic          h_src_ack_i = 1'b0, x_src_ack_i = 1'b0, y_sink_ack_i = 1'b0;
  logic          h_src_done_i = 1'b0, x_src_done_i = 1'b0, y_sink_done_i = 1'b0;
  logic          tap_hs_i = 1'b0;
  logic          h_src_req_o, x_src_req_o, y_sink_req_o;
  logic [AW-1:0] h_src_addr_o, x_src_addr_o, y_sink_addr_o;
  logic [LW-1:0] h_src_len_o, y_sink_len_o;
  logic [LW:0]   x_src_len_o;
  logic          clear_o, busy_o, done_o;

  fir_job_sequencer #(.NB_TAPS(NB), .LEN_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .soft_clear_i(soft_clear_i),
    .len_i(len_i), .x_addr_i(x_addr_i), .h_addr_i(h_addr_i), .y_addr_i(y_addr_i),
    .h_src_req_o(h_src_req_o), .h_src_ack_i(h_src_ack_i),
    .h_src_addr_o(h_src_addr_o), .h_src_len_o(h_src_len_o),
    .x_src_req_o(x_src_req_o), .x_src_ack_i(x_src_ack_i),
    .x_src_addr_o(x_src_addr_o), .x_src_len_o(x_src_len_o),
    .y_sink_req_o(y_sink_req_o), .y_sink_ack_i(y_sink_ack_i),
    .y_sink_addr_o(y_sink_addr_o), .y_sink_len_o(y_sink_len_o),
    .h_src_done_i(h_src_done_i), .x_src_done_i(x_src_done_i),
    .y_sink_done_i(y_sink_done_i), .tap_hs_i(tap_hs_i),
    .clear_o(clear_o), .busy_o(busy_o), .done_o(done_o)
  );

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (job phases) ----------------
  int            m_ph = PH_IDLE;
  int            m_taps = 0;
  bit            m_hf, m_xf, m_yf, m_xacc, m_yacc;
  bit            m_hreq, m_xreq, m_yreq, m_clear, m_busy, m_done;
  logic [LW-1:0] m_len = '0;
  logic [AW-1:0] m_xa = '0, m_ha = '0, m_ya = '0;

  always @(posedge clk) begin
    bit ah, ax, ay;
    ah = m_hreq && h_src_ack_i;
    ax = m_xreq && x_src_ack_i;
    ay = m_yreq && y_sink_ack_i;
    m_clear = 1'b0;
    m_done  = 1'b0;
    if (rst_i) begin
      m_ph = PH_IDLE; m_hreq = 0; m_xreq = 0; m_yreq = 0;
      m_len = '0; m_xa = '0; m_ha = '0; m_ya = '0;
    end else if (soft_clear_i) begin
      m_clear = 1'b1;
      if (m_ph != PH_IDLE) begin
        m_ph = PH_IDLE; m_hreq = 0; m_xreq = 0; m_yreq = 0;
      end
    end else begin
      case (m_ph)
        PH_IDLE: if (start_i) begin
          m_len = len_i; m_xa = x_addr_i; m_ha = h_addr_i; m_ya = y_addr_i;
          if (len_i == 0) begin m_ph = PH_FIN; m_done = 1'b1; end
          else begin m_ph = PH_CLEAR; m_clear = 1'b1; end
        end
        PH_CLEAR: begin
          m_ph = PH_HLOAD; m_hreq = 1'b1; m_taps = 0; m_hf = 0; m_xf = 0; m_yf = 0;
        end
        PH_HLOAD, PH_HFILL: begin
          if (m_ph == PH_HLOAD && ah) begin
            m_hreq = 1'b0; m_ph = PH_HFILL;
          end else if (m_ph == PH_HFILL && m_taps == NB && m_hf) begin
            m_ph = PH_XY; m_xreq = 1'b1; m_yreq = 1'b1; m_xacc = 0; m_yacc = 0;
          end
          if (tap_hs_i && m_taps < NB) m_taps++;
          if (h_src_done_i) m_hf = 1'b1;
        end
        PH_XY, PH_XYWAIT: begin
          if (m_ph == PH_XY) begin
            if (ax) begin m_xreq = 1'b0; m_xacc = 1'b1; end
            if (ay) begin m_yreq = 1'b0; m_yacc = 1'b1; end
            if (m_xacc && m_yacc) m_ph = PH_XYWAIT;
          end else if (m_xf && m_yf) begin
            m_ph = PH_FIN; m_done = 1'b1;
          end
          if (x_src_done_i) m_xf = 1'b1;
          if (y_sink_done_i) m_yf = 1'b1;
        end
        PH_FIN: m_ph = PH_IDLE;
        default: m_ph = PH_IDLE;
      endcase
    end
    m_busy = (m_ph != PH_IDLE);
  end

  // Compare DUT against the model on every falling edge once out of reset.
  always @(negedge clk) begin
    fir_seq_req_t eh, ex, ey;
    if (cmp_en) begin
      eh = '{req: m_hreq, addr: m_ha, len: 17'(NB)};
      ex = '{req: m_xreq, addr: m_xa, len: {1'b0, m_len} + 17'(NB - 1)};
      ey = '{req: m_yreq, addr: m_ya, len: {1'b0, m_len}};
      chk("clear_o", clear_o, m_clear);
      chk("busy_o", busy_o, m_busy);
      chk("done_o", done_o, m_done);
      chk("h_req", h_src_req_o, eh.req);
      chk("x_req", x_src_req_o, ex.req);
      chk("y_req", y_sink_req_o, ey.req);
      if (eh.req) begin chk("h_addr", h_src_addr_o, eh.addr); chk("h_len", h_src_len_o, eh.len); end
      if (ex.req) begin chk("x_addr", x_src_addr_o, ex.addr); chk("x_len", x_src_len_o, ex.len); end
      if (ey.req) begin chk("y_addr", y_sink_addr_o, ey.addr); chk("y_len", y_sink_len_o, ey.len); end
    end
  end

  // ---------------- ack responders with programmable delay ----------------
  int h_dly = 0, x_dly = 0, y_dly = 0;
  int h_hi = 0, x_hi = 0, y_hi = 0;

  // Each ack fires on the (delay+1)-th cycle its request has been high.
  always @(negedge clk) begin
    if (h_src_req_o) begin h_src_ack_i = (h_hi == h_dly); h_hi++; end
    else begin h_src_ack_i = 1'b0; h_hi = 0; end
    if (x_src_req_o) begin x_src_ack_i = (x_hi == x_dly); x_hi++; end
    else begin x_src_ack_i = 1'b0; x_hi = 0; end
    if (y_sink_req_o) begin y_sink_ack_i = (y_hi == y_dly); y_hi++; end
    else begin y_sink_ack_i = 1'b0; y_hi = 0; end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic get_out(input int sel);
    case (sel)
      0: return x_src_req_o;
      1: return done_o;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_out(input int sel, input string name, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      if (get_out(sel)) ok = 1'b1;
      else tick();
    end
    chk(name, ok, 1'b1);
  endtask

  // Start pulse; returns one cycle later. Inputs are scrambled afterwards
  // so that any failure to latch the configuration becomes visible.
  task automatic start_job(input logic [LW-1:0] l, input logic [AW-1:0] xa,
                           input logic [AW-1:0] ha, input logic [AW-1:0] ya);
    start_i = 1'b1; len_i = l; x_addr_i = xa; h_addr_i = ha; y_addr_i = ya;
    tick();
    start_i = 1'b0; len_i = 16'hbeef; x_addr_i = 32'hffff_0000;
    h_addr_i = 32'h0f0f_0f0f; y_addr_i = 32'h1234_5678;
  endtask

  task automatic feed_taps(input int n, input bit with_done);
    for (int i = 0; i < n; i++) begin
      tap_hs_i = 1'b1; h_src_done_i = with_done && (i == n - 1);
      tick();
    end
    tap_hs_i = 1'b0; h_src_done_i = 1'b0;
  endtask

  task automatic pulse_xy_done();
    x_src_done_i = 1'b1; y_sink_done_i = 1'b1;
    tick();
    x_src_done_i = 1'b0; y_sink_done_i = 1'b0;
  endtask

  task automatic run_full(input string tag);
    start_job(16'd8, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000);
    chk({tag, "_clear_c1"}, clear_o, 1'b1);
    chk({tag, "_busy_c1"}, busy_o, 1'b1);
    tick();
    chk({tag, "_hreq_c2"}, h_src_req_o, 1'b1);
    chk({tag, "_hlen"}, h_src_len_o, 16'd4);
    chk({tag, "_haddr"}, h_src_addr_o, 32'h0000_2000);
    chk({tag, "_clear_c2"}, clear_o, 1'b0);
    feed_taps(4, 1'b1);
    wait_out(0, {tag, "_xreq_wait"}, 10);
    chk({tag, "_xlen"}, x_src_len_o, 17'd11);
    chk({tag, "_xaddr"}, x_src_addr_o, 32'h0000_1000);
    chk({tag, "_ylen"}, y_sink_len_o, 16'd8);
    chk({tag, "_yaddr"}, y_sink_addr_o, 32'h0000_3000);
    chk({tag, "_yreq"}, y_sink_req_o, 1'b1);
    tick();
    chk({tag, "_xreq_drop"}, x_src_req_o, 1'b0);
    pulse_xy_done();
    wait_out(1, {tag, "_done_wait"}, 10);
    tick();
    chk({tag, "_done_1cyc"}, done_o, 1'b0);
    chk({tag, "_busy_end"}, busy_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_clear", clear_o, 1'b0);
    rst_i = 1'b0;
    cmp_en = 1'b1;
    tick();

    // 1: nominal job with immediate handshakes
    run_full("t1");

    // 2: y done five cycles before x done
    start_job(16'd5, 32'h10, 32'h20, 32'h30);
    tick();
    feed_taps(4, 1'b1);
    wait_out(0, "t2_xreq_wait", 10);
    tick();
    y_sink_done_i = 1'b1; tick(); y_sink_done_i = 1'b0;
    repeat (4) tick();
    x_src_done_i = 1'b1; tick(); x_src_done_i = 1'b0;
    chk("t2_done_early", done_o, 1'b0);
    tick();
    chk("t2_done", done_o, 1'b1);
    tick();

    // 3: x ack after 3 cycles, y ack after 7
    x_dly = 3; y_dly = 7;
    start_job(16'd3, 32'h100, 32'h200, 32'h300);
    tick();
    feed_taps(4, 1'b1);
    wait_out(0, "t3_xreq_wait", 10);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("t3_xreq_k%0d", k), x_src_req_o, (k < 4));
      chk($sformatf("t3_yreq_k%0d", k), y_sink_req_o, (k < 8));
    end
    x_dly = 0; y_dly = 0;
    pulse_xy_done();
    wait_out(1, "t3_done_wait", 10);
    tick();

    // 4: zero-length job
    start_job(16'd0, 32'h1, 32'h2, 32'h3);
    chk("t4_done", done_o, 1'b1);
    chk("t4_busy", busy_o, 1'b1);
    chk("t4_clear", clear_o, 1'b0);
    chk("t4_hreq", h_src_req_o, 1'b0);
    tick();
    chk("t4_busy_drop", busy_o, 1'b0);
    chk("t4_done_drop", done_o, 1'b0);
    tick();

    // 5: three taps plus h done wait; the fourth tap releases the stream
    start_job(16'd6, 32'h400, 32'h500, 32'h600);
    tick();
    feed_taps(3, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t5_hold_%0d", k), x_src_req_o, 1'b0);
      tick();
    end
    tap_hs_i = 1'b1; tick(); tap_hs_i = 1'b0;
    chk("t5_not_yet", x_src_req_o, 1'b0);
    tick();
    chk("t5_stream", x_src_req_o, 1'b1);
    tick();
    pulse_xy_done();
    wait_out(1, "t5_done_wait", 10);
    tick();

    // 6a: soft clear in STREAM with y still pending, then in WAIT_XY
    y_dly = 7;
    start_job(16'd2, 32'h700, 32'h800, 32'h900);
    tick();
    feed_taps(4, 1'b1);
    wait_out(0, "t6a_xreq_wait", 10);
    tick();
    chk("t6a_ypend", y_sink_req_o, 1'b1);
    soft_clear_i = 1'b1; tick(); soft_clear_i = 1'b0;
    chk("t6a_ydrop", y_sink_req_o, 1'b0);
    chk("t6a_clear", clear_o, 1'b1);
    chk("t6a_busy", busy_o, 1'b0);
    tick();
    chk("t6a_clear_1cyc", clear_o, 1'b0);
    y_dly = 0;
    start_job(16'd2, 32'h700, 32'h800, 32'h900);
    tick();
    feed_taps(4, 1'b1);
    wait_out(0, "t6a2_xreq_wait", 10);
    tick();
    soft_clear_i = 1'b1; tick(); soft_clear_i = 1'b0;
    chk("t6a2_clear", clear_o, 1'b1);
    chk("t6a2_busy", busy_o, 1'b0);
    pulse_xy_done();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t6a2_nodone_%0d", k), done_o, 1'b0);
      tick();
    end

    // 6b: start while busy is ignored
    start_job(16'd8, 32'haaa0, 32'hbbb0, 32'hccc0);
    tick();
    start_i = 1'b1; len_i = 16'd20; x_addr_i = 32'hdead_0000; y_addr_i = 32'hdead_1111;
    tick();
    start_i = 1'b0;
    feed_taps(4, 1'b1);
    wait_out(0, "t6b_xreq_wait", 10);
    chk("t6b_xlen", x_src_len_o, 17'd11);
    chk("t6b_xaddr", x_src_addr_o, 32'haaa0);
    chk("t6b_yaddr", y_sink_addr_o, 32'hccc0);
    tick();
    pulse_xy_done();
    wait_out(1, "t6b_done_wait", 10);
    tick();

    // 6c: reset in LOAD_H, then a fresh job
    h_dly = 5;
    start_job(16'd8, 32'h5, 32'h6, 32'h7);
    tick();
    chk("t6c_hreq", h_src_req_o, 1'b1);
    tick();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk("t6c_hreq0", h_src_req_o, 1'b0);
    chk("t6c_haddr0", h_src_addr_o, 32'h0);
    chk("t6c_hlen0", h_src_len_o, 16'h0);
    chk("t6c_busy0", busy_o, 1'b0);
    chk("t6c_clear0", clear_o, 1'b0);
    chk("t6c_done0", done_o, 1'b0);
    h_dly = 0;
    tick();
    run_full("t6c");

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
